// File: rtl/xm_latch.sv
// xm_latch: execute-to-memory pipeline register.
// Captures the execute-stage instruction, rewrites rd/result for overflow
// traps and jal links, and keeps saturating stall/flush counters.
//
// Pipeline control: stall and flush are level inputs sampled on every rising
// edge. flush wins and loads a bubble. Otherwise stall holds the register.
// Otherwise the register loads the execute stage; if x_valid is 0, it loads a
// bubble instead. There is no ready/backpressure path out of this block.
module xm_latch #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             x_valid,
  input  logic [4:0]       x_opcode,
  input  logic [4:0]       x_aluop,
  input  logic [4:0]       x_rd,
  input  logic [WIDTH-1:0] x_alu_result,
  input  logic [WIDTH-1:0] x_data_b,
  input  logic             x_overflow,
  input  logic [WIDTH-1:0] x_pc,
  output logic             m_valid,
  output logic [4:0]       opcode_old,
  output logic [4:0]       rd_old,
  output logic [WIDTH-1:0] m_result,
  output logic [WIDTH-1:0] m_data_b,
  output logic [WIDTH-1:0] m_pc,
  output logic             m_wren,
  output logic             m_rf_we,
  output logic [CNTW-1:0]  stall_count,
  output logic [CNTW-1:0]  flush_count
);

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] AL_ADD  = 5'b00000;
  localparam logic [4:0] AL_SUB  = 5'b00001;
  localparam logic [4:0] RD_EXC  = 5'd30;
  localparam logic [4:0] RD_LINK = 5'd31;
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [4:0]       rd_next;
  logic [WIDTH-1:0] result_next;

  // Destination/result rewrite for jal link and overflow exception codes.
  always_comb begin
    rd_next     = x_rd;
    result_next = x_alu_result;
    if (x_opcode == OP_JAL) begin
      rd_next     = RD_LINK;
      result_next = x_pc + WIDTH'(1);
    end else if (x_overflow) begin
      if (x_opcode == OP_ALU && x_aluop == AL_ADD) begin
        rd_next     = RD_EXC;
        result_next = WIDTH'(1);
      end else if (x_opcode == OP_ADDI) begin
        rd_next     = RD_EXC;
        result_next = WIDTH'(2);
      end else if (x_opcode == OP_ALU && x_aluop == AL_SUB) begin
        rd_next     = RD_EXC;
        result_next = WIDTH'(3);
      end
    end
  end

  // Pipeline register: reset > flush (bubble) > stall (hold) > load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_valid    <= 1'b0;
      opcode_old <= '0;
      rd_old     <= '0;
      m_result   <= '0;
      m_data_b   <= '0;
      m_pc       <= '0;
    end else if (flush || (!stall && !x_valid)) begin
      m_valid    <= 1'b0;
      opcode_old <= '0;
      rd_old     <= '0;
      m_result   <= '0;
      m_data_b   <= '0;
      m_pc       <= '0;
    end else if (!stall) begin
      m_valid    <= 1'b1;
      opcode_old <= x_opcode;
      rd_old     <= rd_next;
      m_result   <= result_next;
      m_data_b   <= x_data_b;
      m_pc       <= x_pc;
    end
  end

  // Saturating counters; a stall that coincides with a flush counts as a flush only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (flush) begin
      if (flush_count != CNT_MAX) flush_count <= flush_count + CNTW'(1);
    end else if (stall) begin
      if (stall_count != CNT_MAX) stall_count <= stall_count + CNTW'(1);
    end
  end

  // Memory write and register-file write enables decoded from the latched stage.
  always_comb begin
    m_wren  = m_valid && (opcode_old == OP_SW);
    m_rf_we = m_valid && (rd_old != 5'd0) &&
              ((opcode_old == OP_ALU) || (opcode_old == OP_ADDI) ||
               (opcode_old == OP_LW)  || (opcode_old == OP_JAL));
  end

endmodule

// File: tb/tb_xm_latch.sv
// tb_xm_latch: directed bench for xm_latch with a behavioural model and
// per-cycle comparison, plus literal expectations for key scenarios.
module tb_xm_latch;
  localparam int WIDTH = 32;
  localparam int CNTW  = 16;
  localparam int W     = 1 + 5 + 5 + 3 * WIDTH + 1 + 1 + 2 * CNTW;
  localparam int unsigned CMAX = (1 << CNTW) - 1;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset = 1'b0;

  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic             x_valid = 1'b0;
  logic [4:0]       x_opcode = '0;
  logic [4:0]       x_aluop = '0;
  logic [4:0]       x_rd = '0;
  logic [WIDTH-1:0] x_alu_result = '0;
  logic [WIDTH-1:0] x_data_b = '0;
  logic             x_overflow = 1'b0;
  logic [WIDTH-1:0] x_pc = '0;

  logic             m_valid;
  logic [4:0]       opcode_old;
  logic [4:0]       rd_old;
  logic [WIDTH-1:0] m_result;
  logic [WIDTH-1:0] m_data_b;
  logic [WIDTH-1:0] m_pc;
  logic             m_wren;
  logic             m_rf_we;
  logic [CNTW-1:0]  stall_count;
  logic [CNTW-1:0]  flush_count;

  xm_latch #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .x_valid(x_valid), .x_opcode(x_opcode), .x_aluop(x_aluop), .x_rd(x_rd),
    .x_alu_result(x_alu_result), .x_data_b(x_data_b), .x_overflow(x_overflow),
    .x_pc(x_pc), .m_valid(m_valid), .opcode_old(opcode_old), .rd_old(rd_old),
    .m_result(m_result), .m_data_b(m_data_b), .m_pc(m_pc), .m_wren(m_wren),
    .m_rf_we(m_rf_we), .stall_count(stall_count), .flush_count(flush_count)
  );

  logic [W-1:0] dut_vec;
  assign dut_vec = {m_valid, opcode_old, rd_old, m_result, m_data_b, m_pc,
                    m_wren, m_rf_we, stall_count, flush_count};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic             mv = 1'b0;
  logic [4:0]       mop = '0;
  logic [4:0]       mrd = '0;
  logic [WIDTH-1:0] mres = '0;
  logic [WIDTH-1:0] mdb = '0;
  logic [WIDTH-1:0] mpc = '0;
  int unsigned      sc = 0;
  int unsigned      fc = 0;
  logic [W-1:0]     exp_q[$];

  function automatic logic [W-1:0] model_vec();
    logic wren, rfwe;
    wren = mv && (mop == 5'd7);
    rfwe = mv && (mop inside {5'd0, 5'd5, 5'd8, 5'd3}) && (mrd != 5'd0);
    return {mv, mop, mrd, mres, mdb, mpc, wren, rfwe, CNTW'(sc), CNTW'(fc)};
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mv = 0; mop = 0; mrd = 0; mres = 0; mdb = 0; mpc = 0; sc = 0; fc = 0;
    end else if (flush) begin
      if (fc < CMAX) fc++;
      mv = 0; mop = 0; mrd = 0; mres = 0; mdb = 0; mpc = 0;
    end else if (stall) begin
      if (sc < CMAX) sc++;
    end else if (x_valid) begin
      mv = 1; mop = x_opcode; mrd = x_rd; mres = x_alu_result; mdb = x_data_b; mpc = x_pc;
      if (x_opcode == 5'd3) begin
        mrd = 31; mres = x_pc + 1;
      end else if (x_overflow) begin
        if (x_opcode == 5'd0 && x_aluop == 5'd0) begin mrd = 30; mres = 1; end
        else if (x_opcode == 5'd5)               begin mrd = 30; mres = 2; end
        else if (x_opcode == 5'd0 && x_aluop == 5'd1) begin mrd = 30; mres = 3; end
      end
    end else begin
      mv = 0; mop = 0; mrd = 0; mres = 0; mdb = 0; mpc = 0;
    end
    exp_q.delete();
    exp_q.push_back(model_vec());
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clock) begin : cmp
    logic [W-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (dut_vec !== e) begin
        errors++;
        $display("FAIL model_cmp: got 0x%0h expected 0x%0h at %0t", dut_vec, e, $time);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] al,
                       input logic [4:0] rd, input logic [WIDTH-1:0] res,
                       input logic [WIDTH-1:0] db, input logic [WIDTH-1:0] pc,
                       input logic ovf);
    x_valid = v; x_opcode = op; x_aluop = al; x_rd = rd;
    x_alu_result = res; x_data_b = db; x_pc = pc; x_overflow = ovf;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(m_valid), 64'd0);
    check({tag, "_rd"}, 64'(rd_old), 64'd0);
    check({tag, "_op"}, 64'(opcode_old), 64'd0);
    check({tag, "_result"}, 64'(m_result), 64'd0);
    check({tag, "_pc"}, 64'(m_pc), 64'd0);
    check({tag, "_scnt"}, 64'(stall_count), 64'd0);
    check({tag, "_fcnt"}, 64'(flush_count), 64'd0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    @(negedge clock);
    @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;
    #1 check("release_hold", 64'(m_valid), 64'd0);

    // add rd5 result 0x10
    drive(1, 5'd0, 5'd0, 5'd5, 32'h10, 32'h99, 32'h40, 0); step();
    check("add_rd", 64'(rd_old), 64'd5);
    check("add_res", 64'(m_result), 64'h10);
    check("add_rfwe", 64'(m_rf_we), 64'd1);
    check("add_wren", 64'(m_wren), 64'd0);
    check("add_pc", 64'(m_pc), 64'h40);

    // overflow rewrites
    drive(1, 5'd5, 5'd0, 5'd7, 32'h1234, 32'h0, 32'h41, 1); step();
    check("addi_ovf_rd", 64'(rd_old), 64'd30);
    check("addi_ovf_res", 64'(m_result), 64'd2);
    drive(1, 5'd0, 5'd1, 5'd7, 32'h1234, 32'h0, 32'h42, 1); step();
    check("sub_ovf_rd", 64'(rd_old), 64'd30);
    check("sub_ovf_res", 64'(m_result), 64'd3);
    drive(1, 5'd0, 5'd0, 5'd7, 32'h1234, 32'h0, 32'h43, 1); step();
    check("add_ovf_res", 64'(m_result), 64'd1);
    drive(1, 5'd8, 5'd0, 5'd9, 32'h55, 32'h0, 32'h44, 1); step();
    check("lw_ovf_rd", 64'(rd_old), 64'd9);
    check("lw_ovf_res", 64'(m_result), 64'h55);
    drive(1, 5'd0, 5'd2, 5'd9, 32'h66, 32'h0, 32'h44, 1); step();
    check("alu2_ovf_rd", 64'(rd_old), 64'd9);
    check("alu2_ovf_res", 64'(m_result), 64'h66);

    // sw then 3 stall cycles
    drive(1, 5'd7, 5'd0, 5'd3, 32'h100, 32'hdead, 32'h45, 0); step();
    check("sw_wren", 64'(m_wren), 64'd1);
    check("sw_rfwe", 64'(m_rf_we), 64'd0);
    check("sw_datab", 64'(m_data_b), 64'hdead);
    stall = 1;
    drive(1, 5'd0, 5'd0, 5'd4, 32'h777, 32'h1, 32'h99, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_res", 64'(m_result), 64'h100);
      check("stall_wren", 64'(m_wren), 64'd1);
    end
    check("stall_cnt3", 64'(stall_count), 64'd3);

    // stall + flush with valid lw
    flush = 1;
    drive(1, 5'd8, 5'd0, 5'd6, 32'h200, 32'h0, 32'h46, 0); step();
    check("sf_valid", 64'(m_valid), 64'd0);
    check("sf_res", 64'(m_result), 64'd0);
    check("sf_fcnt", 64'(flush_count), 64'd1);
    check("sf_scnt", 64'(stall_count), 64'd3);
    stall = 0; flush = 0;

    // jal wraparound
    drive(1, 5'd3, 5'd0, 5'd2, 32'h5, 32'h0, 32'hFFFF_FFFF, 0); step();
    check("jal_rd", 64'(rd_old), 64'd31);
    check("jal_res", 64'(m_result), 64'd0);
    check("jal_rfwe", 64'(m_rf_we), 64'd1);

    // rd=0 write suppression, then invalid bubble
    drive(1, 5'd0, 5'd0, 5'd0, 32'h8, 32'h0, 32'h47, 0); step();
    check("rd0_valid", 64'(m_valid), 64'd1);
    check("rd0_rfwe", 64'(m_rf_we), 64'd0);
    drive(0, 5'd0, 5'd0, 5'd5, 32'h10, 32'h0, 32'h48, 0); step();
    check("inv_valid", 64'(m_valid), 64'd0);
    check("inv_rd", 64'(rd_old), 64'd0);

    // reset mid-stall discards held instruction
    drive(1, 5'd0, 5'd0, 5'd5, 32'h33, 32'h0, 32'h50, 0); step();
    stall = 1; step();
    check("held_rd", 64'(rd_old), 64'd5);
    #2 reset = 0;
    #1 check_all_zero("midstall_rst");
    @(negedge clock);
    reset = 1;
    step();
    check("post_rst_valid", 64'(m_valid), 64'd0);
    check("post_rst_res", 64'(m_result), 64'd0);
    check("post_rst_scnt", 64'(stall_count), 64'd1);

    // saturate stall counter
    repeat (65534) step();
    check("sat_cnt", 64'(stall_count), 64'hFFFF);
    step();
    check("sat_hold", 64'(stall_count), 64'hFFFF);
    #2 reset = 0;
    #1 check_all_zero("final_rst");
    @(negedge clock);
    reset = 1; stall = 0;
    drive(1, 5'd8, 5'd0, 5'd4, 32'h77, 32'h0, 32'h60, 0); step();
    check("final_valid", 64'(m_valid), 64'd1);
    check("final_rfwe", 64'(m_rf_we), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xm_latch.md
XM_LATCH -- requirements
Module: xm_latch

Interface
REQ-001 Parameter WIDTH, default 32, data/PC width.
REQ-002 Parameter CNTW, default 16, performance counter width.
REQ-003 clock  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 stall  in  1  hold all pipeline state this cycle.
REQ-006 flush  in  1  load a bubble this cycle (branch/jump squash).
REQ-007 x_valid  in  1  execute-stage instruction is real.
REQ-008 x_opcode  in  5  execute-stage opcode.
REQ-009 x_aluop  in  5  execute-stage ALU op field.
REQ-010 x_rd  in  5  execute-stage destination register.
REQ-011 x_alu_result  in  WIDTH  ALU result / memory address.
REQ-012 x_data_b  in  WIDTH  store data (rd value for sw).
REQ-013 x_overflow  in  1  ALU overflow flag.
REQ-014 x_pc  in  WIDTH  instruction PC.
REQ-015 m_valid  out  1  memory-stage instruction is real.
REQ-016 opcode_old  out  5  latched opcode, feeds MX bypass detector.
REQ-017 rd_old  out  5  latched (possibly rewritten) destination, feeds MX bypass detector.
REQ-018 m_result  out  WIDTH  latched (possibly rewritten) result/address.
REQ-019 m_data_b  out  WIDTH  latched store data.
REQ-020 m_pc  out  WIDTH  latched PC.
REQ-021 m_wren  out  1  data-memory write enable.
REQ-022 m_rf_we  out  1  register-file write enable carried forward.
REQ-023 stall_count  out  CNTW  saturating count of stall cycles.
REQ-024 flush_count  out  CNTW  saturating count of flush cycles.

Function
REQ-025 Per-edge priority SHALL be: reset > flush > stall > load.
REQ-026 Flush SHALL load a bubble: m_valid=0, opcode_old=0, rd_old=0, m_result=0, m_data_b=0, m_pc=0; flush with stall SHALL still bubble.
REQ-027 Stall without flush SHALL hold every pipeline output unchanged.
REQ-028 Load with x_valid=0 SHALL load a bubble identical to REQ-026.
REQ-029 Load with x_valid=1 SHALL capture all x_* fields with latency exactly one cycle, subject to REQ-030..032.
REQ-030 Overflow rewrite: x_overflow=1 with opcode 00000/aluop 00000 (add) SHALL latch rd_old=30, m_result=1; opcode 00101 (addi) SHALL latch rd_old=30, m_result=2; opcode 00000/aluop 00001 (sub) SHALL latch rd_old=30, m_result=3.
REQ-031 x_overflow SHALL be ignored for all other opcode/aluop pairs.
REQ-032 jal (opcode 00011) SHALL latch rd_old=31, m_result=x_pc+1 (WIDTH bits, wrap on overflow).
REQ-033 m_wren SHALL be combinational: m_valid AND opcode_old==00111.
REQ-034 m_rf_we SHALL be combinational: m_valid AND opcode_old in {00000, 00101, 01000, 00011} AND rd_old!=0.
REQ-035 stall_count SHALL increment on every edge with stall=1 and flush=0, saturating at all-ones.
REQ-036 flush_count SHALL increment on every edge with flush=1, saturating at all-ones.
REQ-037 Counters SHALL update on the same edges as the pipeline state (REQ-035, REQ-036), independent of x_valid.

Reset
REQ-038 reset=0 SHALL asynchronously force the bubble state of REQ-026 and both counters to 0, regardless of clock, stall or flush.
REQ-039 Release of reset SHALL take effect at the first rising edge with reset=1; no output SHALL change between assertion and that edge.
REQ-040 Reset asserted mid-stall SHALL discard the held instruction.

Verification
REQ-041 Load add x_rd=5, x_alu_result=0x10 -> next cycle rd_old=5, m_result=0x10, m_rf_we=1, m_wren=0.
REQ-042 Load addi with x_overflow=1, x_rd=7 -> rd_old=30, m_result=2; repeat with sub -> m_result=3.
REQ-043 Load sw, then hold stall=1 for 3 cycles -> outputs frozen, m_wren=1 throughout, stall_count=3.
REQ-044 stall=1 and flush=1 together with a valid lw -> bubble loaded, m_valid=0, flush_count=1, stall_count unchanged.
REQ-045 jal at x_pc=0xFFFFFFFF -> rd_old=31, m_result=0x00000000, m_rf_we=1.
REQ-046 Force stall_count to 0xFFFF via 65535 stall cycles, stall once more -> stays 0xFFFF; then pull reset low between edges -> all outputs 0 immediately.
